// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store path.
// One transaction is in flight at a time. Responses go back to their owner, and flushed fetches are dropped.
//
// state    | meaning
// IDLE     | arbitrating; drives the winner onto the memory bus
// IF_WAIT  | fetch granted, waiting for its response
// DM_WAIT  | load/store granted, waiting for its response
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 3
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,
    input  logic                i_flush,
    input  logic                i_dm_rd_en,
    input  logic                i_dm_wr_en,
    input  logic [ADDR_W-1:0]   i_dm_addr,
    input  logic [DATA_W-1:0]   i_dm_wdata,
    input  logic [DATA_W/8-1:0] i_dm_be,
    output logic                o_dm_gnt,
    output logic                o_dm_rvalid,
    output logic [DATA_W-1:0]   o_dm_rdata,
    output logic                o_stall,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_be,
    input  logic                i_mem_gnt,
    input  logic                i_mem_rvalid,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    localparam int SW = (MAX_DM_STREAK < 1) ? 1 : $clog2(MAX_DM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        DM_WAIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] dm_streak_q, dm_streak_d;
    logic          drop_if_q, drop_if_d;

    logic dm_req;
    logic force_if;
    logic dm_win;
    logic if_win;

    // Both enables high counts as a store.
    assign dm_req   = i_dm_rd_en | i_dm_wr_en;
    assign force_if = i_if_req && (dm_streak_q == STREAK_MAX);
    assign dm_win   = dm_req && !force_if;
    assign if_win   = i_if_req && !dm_win;

    always_comb begin
        state_d     = state_q;
        dm_streak_d = dm_streak_q;
        drop_if_d   = drop_if_q;
        o_if_gnt    = 1'b0;
        o_if_rvalid = 1'b0;
        o_if_rdata  = '0;
        o_dm_gnt    = 1'b0;
        o_dm_rvalid = 1'b0;
        o_dm_rdata  = '0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_be    = '0;

        case (state_q)
            IDLE: begin
                if (dm_win) begin
                    o_mem_req   = 1'b1;
                    o_mem_we    = i_dm_wr_en;
                    o_mem_addr  = i_dm_addr;
                    o_mem_wdata = i_dm_wdata;
                    o_mem_be    = i_dm_be;
                end else if (if_win) begin
                    o_mem_req   = 1'b1;
                    o_mem_addr  = i_if_addr;
                    o_mem_be    = '1;
                end
                if (i_mem_gnt) begin
                    if (dm_win) begin
                        o_dm_gnt = 1'b1;
                        state_d  = DM_WAIT;
                        if (!i_if_req)
                            dm_streak_d = '0;
                        else if (dm_streak_q != STREAK_MAX)
                            dm_streak_d = dm_streak_q + SW'(1);
                    end else if (if_win) begin
                        o_if_gnt    = 1'b1;
                        state_d     = IF_WAIT;
                        dm_streak_d = '0;
                    end
                end
            end
            IF_WAIT: begin
                if (i_mem_rvalid) begin
                    // A flush in the response cycle itself also kills the data.
                    o_if_rvalid = ~drop_if_q & ~i_flush;
                    o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
                    drop_if_d   = 1'b0;
                    state_d     = IDLE;
                end else if (i_flush) begin
                    drop_if_d = 1'b1;
                end
            end
            DM_WAIT: begin
                o_dm_rvalid = i_mem_rvalid;
                o_dm_rdata  = i_mem_rvalid ? i_mem_rdata : '0;
                if (i_mem_rvalid)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_stall = dm_req & ~((state_q == DM_WAIT) & i_mem_rvalid);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            dm_streak_q <= '0;
            drop_if_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dm_streak_q <= dm_streak_d;
            drop_if_q   <= drop_if_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, starvation guard,
// flush, memory back-pressure and reset in the middle of a transaction.
module tb_mem_port_arbiter;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_if_req;
   logic [31:0] i_if_addr;
   logic        o_if_gnt;
   logic        o_if_rvalid;
   logic [31:0] o_if_rdata;
   logic        i_flush;
   logic        i_dm_rd_en;
   logic        i_dm_wr_en;
   logic [31:0] i_dm_addr;
   logic [31:0] i_dm_wdata;
   logic [3:0]  i_dm_be;
   logic        o_dm_gnt;
   logic        o_dm_rvalid;
   logic [31:0] o_dm_rdata;
   logic        o_stall;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_be;
   logic        i_mem_gnt;
   logic        i_mem_rvalid;
   logic [31:0] i_mem_rdata;

   int total = 0;
   int bad   = 0;
   int gnt_cnt;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(3)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_if_req(i_if_req), .i_if_addr(i_if_addr),
      .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
      .i_flush(i_flush),
      .i_dm_rd_en(i_dm_rd_en), .i_dm_wr_en(i_dm_wr_en), .i_dm_addr(i_dm_addr),
      .i_dm_wdata(i_dm_wdata), .i_dm_be(i_dm_be),
      .o_dm_gnt(o_dm_gnt), .o_dm_rvalid(o_dm_rvalid), .o_dm_rdata(o_dm_rdata),
      .o_stall(o_stall),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
      .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input bit ok);
      total++;
      if (!ok) begin
         bad++;
         $error("FAIL %s", tag);
      end
   endtask

   // Advance past the next rising edge; inputs driven after this are sampled on the following edge.
   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic quiet_inputs();
      i_if_req = 0; i_if_addr = '0; i_flush = 0;
      i_dm_rd_en = 0; i_dm_wr_en = 0; i_dm_addr = '0; i_dm_wdata = '0; i_dm_be = '0;
      i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_req"}, o_mem_req === 1'b0);
      chk({tag, "_outs"}, {o_if_gnt, o_if_rvalid, o_dm_gnt, o_dm_rvalid, o_stall, o_mem_we} === 6'b0);
      chk({tag, "_data"}, {o_if_rdata, o_dm_rdata} === 64'b0);
      chk({tag, "_bus"}, {o_mem_addr, o_mem_be} === 36'b0);
      chk({tag, "_wdata"}, o_mem_wdata === 32'b0);
   endtask

   initial begin
      quiet_inputs();
      i_rst_n = 0;
      #1;
      chk_all_zero("rst");
      cyc(); cyc();
      i_rst_n = 1;
      cyc();
      #1 chk_all_zero("idle");

      // Lone fetch: grant at cycle 0, data at cycle 1, next fetch granted at cycle 2.
      cyc();
      i_if_req = 1; i_if_addr = 32'h100; i_mem_gnt = 1;
      #1;
      chk("f_gnt", o_if_gnt === 1'b1);
      chk("f_req", o_mem_req === 1'b1);
      chk("f_addr", o_mem_addr === 32'h100);
      chk("f_we_be", {o_mem_we, o_mem_be} === 5'b0_1111);
      chk("f_stall", o_stall === 1'b0);
      cyc();
      i_if_addr = 32'h104; i_mem_rvalid = 1; i_mem_rdata = 32'h00500093;
      #1;
      chk("f_rvalid", o_if_rvalid === 1'b1);
      chk("f_rdata", o_if_rdata === 32'h00500093);
      chk("f_wait_noreq", {o_mem_req, o_if_gnt} === 2'b00);
      cyc();
      i_mem_rvalid = 0; i_mem_rdata = '0;
      #1;
      chk("f2_gnt", o_if_gnt === 1'b1);
      chk("f2_addr", o_mem_addr === 32'h104);
      chk("f2_rvalid0", {o_if_rvalid, o_if_rdata} === 33'b0);
      cyc();
      i_if_req = 0; i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = 32'h11;
      #1 chk("f2_rdata", {o_if_rvalid, o_if_rdata} === {1'b1, 32'h11});
      cyc();
      quiet_inputs();

      // Contention with streak at 0: DM wins and stalls until its response cycle.
      cyc();
      i_if_req = 1; i_if_addr = 32'h300; i_dm_rd_en = 1; i_dm_addr = 32'h2000;
      i_dm_be = 4'hF; i_mem_gnt = 1;
      #1;
      chk("c_gnts", {o_dm_gnt, o_if_gnt} === 2'b10);
      chk("c_addr", o_mem_addr === 32'h2000);
      chk("c_we", o_mem_we === 1'b0);
      chk("c_stall0", o_stall === 1'b1);
      cyc();
      i_mem_gnt = 0;
      #1;
      chk("c_stall1", o_stall === 1'b1);
      chk("c_norv", {o_dm_rvalid, o_dm_rdata} === 33'b0);
      cyc();
      i_mem_rvalid = 1; i_mem_rdata = 32'hDEADBEEF;
      #1;
      chk("c_rvalid", o_dm_rvalid === 1'b1);
      chk("c_rdata", o_dm_rdata === 32'hDEADBEEF);
      chk("c_stall_rv", o_stall === 1'b0);
      chk("c_if_rv", o_if_rvalid === 1'b0);
      cyc();
      i_dm_rd_en = 0; i_mem_rvalid = 0; i_mem_rdata = '0; i_mem_gnt = 1;
      #1 chk("c_if_gnt", {o_if_gnt, o_mem_addr} === {1'b1, 32'h300});
      cyc();
      i_if_req = 0; i_mem_gnt = 0; i_mem_rvalid = 1;
      cyc();
      quiet_inputs();

      // Starvation guard: three DM stores win, then the pending fetch is forced through.
      i_if_req = 1; i_if_addr = 32'h400; i_dm_wr_en = 1; i_dm_be = 4'b0011;
      for (int k = 0; k < 3; k++) begin
         i_dm_addr = 32'h3000 + 32'(k * 4); i_dm_wdata = 32'hA0 + 32'(k);
         i_mem_gnt = 1; i_mem_rvalid = 0;
         #1;
         chk($sformatf("s%0d_gnt", k), {o_dm_gnt, o_if_gnt} === 2'b10);
         chk($sformatf("s%0d_bus", k), {o_mem_we, o_mem_be, o_mem_wdata} === {1'b1, 4'b0011, 32'hA0 + 32'(k)});
         cyc();
         i_mem_gnt = 0; i_mem_rvalid = 1;
         #1 chk($sformatf("s%0d_done", k), {o_dm_rvalid, o_stall} === 2'b10);
         cyc();
      end
      i_dm_addr = 32'h300C; i_dm_wdata = 32'hA3; i_mem_gnt = 1; i_mem_rvalid = 0;
      #1;
      chk("s_force_gnt", {o_if_gnt, o_dm_gnt} === 2'b10);
      chk("s_force_bus", {o_mem_addr, o_mem_we, o_mem_be} === {32'h400, 1'b0, 4'hF});
      chk("s_force_stall", o_stall === 1'b1);
      cyc();
      i_if_addr = 32'h404; i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = 32'h77;
      #1;
      chk("s_if_rv", {o_if_rvalid, o_if_rdata} === {1'b1, 32'h77});
      chk("s_streak", dut.dm_streak_q === '0);
      cyc();
      i_mem_gnt = 1; i_mem_rvalid = 0;
      #1 chk("s_dm_again", {o_dm_gnt, o_if_gnt, o_mem_addr} === {2'b10, 32'h300C});
      cyc();
      i_mem_gnt = 0; i_mem_rvalid = 1;
      cyc();
      quiet_inputs();

      // Flush: the outstanding fetch response is dropped, the redirect fetch is normal.
      cyc();
      i_if_req = 1; i_if_addr = 32'h200; i_mem_gnt = 1;
      #1 chk("fl_gnt", o_if_gnt === 1'b1);
      cyc();
      i_if_addr = 32'h204; i_flush = 1;
      #1 chk("fl_pulse", {o_if_rvalid, o_mem_req} === 2'b00);
      cyc();
      i_flush = 0; i_if_addr = 32'h800;
      #1 chk("fl_wait", {o_if_rvalid, o_if_gnt} === 2'b00);
      cyc();
      i_mem_rvalid = 1; i_mem_rdata = 32'h1234;
      #1 chk("fl_drop", {o_if_rvalid, o_if_rdata} === 33'b0);
      cyc();
      i_mem_rvalid = 0; i_mem_rdata = '0;
      #1 chk("fl_new_gnt", {o_if_gnt, o_mem_addr} === {1'b1, 32'h800});
      cyc();
      i_mem_rvalid = 1; i_mem_rdata = 32'h5678; i_if_addr = 32'h900; i_mem_gnt = 0;
      #1 chk("fl_new_rv", {o_if_rvalid, o_if_rdata} === {1'b1, 32'h5678});
      cyc();
      // Flush while idle does not touch the fetch being presented.
      i_mem_rvalid = 0; i_flush = 1; i_mem_gnt = 1;
      #1 chk("fl_idle_gnt", {o_if_gnt, o_mem_addr} === {1'b1, 32'h900});
      cyc();
      i_flush = 0; i_if_req = 0; i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = 32'h9;
      #1 chk("fl_idle_rv", {o_if_rvalid, o_if_rdata} === {1'b1, 32'h9});
      cyc();
      quiet_inputs();

      // Back-pressure: request and bus stay stable while memory withholds the grant.
      cyc();
      i_dm_rd_en = 1; i_dm_addr = 32'h2040; i_dm_be = 4'b1100;
      gnt_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("bp%0d_bus", k), {o_mem_req, o_mem_addr, o_mem_be, o_stall} === {1'b1, 32'h2040, 4'b1100, 1'b1});
         gnt_cnt += int'(o_dm_gnt);
         cyc();
      end
      i_mem_gnt = 1;
      #1 gnt_cnt += int'(o_dm_gnt);
      cyc();
      i_mem_gnt = 0;
      #1;
      gnt_cnt += int'(o_dm_gnt);
      chk("bp_wait_stall", o_stall === 1'b1);
      cyc();
      i_mem_rvalid = 1; i_mem_rdata = 32'hCAFE0001;
      #1;
      gnt_cnt += int'(o_dm_gnt);
      chk("bp_rv", {o_dm_rvalid, o_dm_rdata, o_stall} === {1'b1, 32'hCAFE0001, 1'b0});
      chk("bp_gnt_once", gnt_cnt === 1);
      cyc();
      quiet_inputs();

      // Reset while in DM_WAIT: outputs clear at once, and a stray response is ignored.
      cyc();
      i_dm_rd_en = 1; i_dm_addr = 32'h2080; i_dm_be = 4'hF; i_mem_gnt = 1;
      #1 chk("r_gnt", o_dm_gnt === 1'b1);
      cyc();
      quiet_inputs();
      i_rst_n = 0;
      #1 chk_all_zero("r_async");
      cyc();
      i_rst_n = 1;
      i_mem_rvalid = 1; i_mem_rdata = 32'hAA;
      #1;
      chk_all_zero("r_stray");
      chk("r_streak", dut.dm_streak_q === '0);
      cyc();
      quiet_inputs();
      i_if_req = 1; i_if_addr = 32'h100; i_mem_gnt = 1;
      #1 chk("r_fetch_ok", {o_if_gnt, o_mem_addr} === {1'b1, 32'h100});
      cyc();
      quiet_inputs();
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
